// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared opcode encodings, FSM state type and opcode helpers
//                for the multi-cycle sequential ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Opcode encodings carried on SELECT
    localparam logic [2:0] c_OP_FWD = 3'b000;  // result = B
    localparam logic [2:0] c_OP_ADD = 3'b001;  // result = A + B
    localparam logic [2:0] c_OP_AND = 3'b010;  // result = A & B
    localparam logic [2:0] c_OP_OR  = 3'b011;  // result = A | B
    localparam logic [2:0] c_OP_SUB = 3'b100;  // result = A - B
    localparam logic [2:0] c_OP_SLL = 3'b101;  // result = A << B[SHW-1:0]
    localparam logic [2:0] c_OP_SRL = 3'b110;  // result = A >> B[SHW-1:0]
    localparam logic [2:0] c_OP_MUL = 3'b111;  // {hi,lo} = A * B unsigned

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // True for the two iterative shift opcodes
    function automatic logic is_shift(input logic [2:0] op);
        return (op == c_OP_SLL) || (op == c_OP_SRL);
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_seq_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_mul_iter
//  Description : Radix-2 shift-add unsigned multiplier. One multiplier bit is
//                consumed per cycle, LSB first; WIDTH iterations per product.
//                o_last flags the cycle whose closing edge completes the
//                product, and o_product carries that completed value.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q,  prod_d;   // {partial sum, remaining multiplier}
    logic [CW-1:0]      cnt_q,   cnt_d;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_step;

    // One shift-add step: add multiplicand into upper half if LSB set, then shift right
    always_comb begin
        w_addend = prod_q[0] ? mcand_q : '0;
        w_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
        w_step   = {w_sum, prod_q[WIDTH-1:1]};
    end

    // Load operands on start, otherwise iterate while the counter is non-zero
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
        if (i_start) begin
            mcand_d = i_a;
            prod_d  = {{WIDTH{1'b0}}, i_b};
            cnt_d   = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            prod_d  = w_step;
            cnt_d   = cnt_q - CW'(1);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_last    = (cnt_q == CW'(1));
    assign o_product = w_step;

endmodule : alu_seq_mul_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Multi-cycle ALU with start/busy/done handshake. Single-cycle
//                logic/arithmetic ops, one-bit-per-cycle shifts and an
//                iterative shift-add multiplier. Result and flags are
//                registered and hold until the next DONE.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [2:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic [WIDTH-1:0] RESULT_HI,
    output logic             BUSY,
    output logic             DONE,
    output logic             ZERO,
    output logic             CARRY,
    output logic             OVERFLOW
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;          // operand A; doubles as the shift register
    logic [WIDTH-1:0]   b_q, b_d;
    logic [SHW-1:0]     cnt_q, cnt_d;      // remaining EXEC cycles
    logic               shift_en_q, shift_en_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_shift_val;
    logic               w_shift_out;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic               w_ovf;
    logic               w_mul_start;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_mul_product;

    assign w_shamt = DATA2[SHW-1:0];

    alu_seq_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (CLK),
        .rst       (RESET),
        .i_start   (w_mul_start),
        .i_a       (DATA1),
        .i_b       (DATA2),
        .o_last    (w_mul_last),
        .o_product (w_mul_product)
    );

    // Operation results from the latched operands, including one shift step
    always_comb begin
        w_sum       = {1'b0, a_q} + {1'b0, b_q};
        w_diff      = {1'b0, a_q} - {1'b0, b_q};
        w_shift_val = a_q;
        w_shift_out = 1'b0;
        w_res       = '0;
        w_carry     = 1'b0;
        w_ovf       = 1'b0;
        case (op_q)
            c_OP_FWD: w_res = b_q;
            c_OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            c_OP_AND: w_res = a_q & b_q;
            c_OP_OR:  w_res = a_q | b_q;
            c_OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];       // borrow: A < B unsigned
                w_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (w_diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            c_OP_SLL: begin
                w_shift_val = {a_q[WIDTH-2:0], 1'b0};
                w_shift_out = a_q[WIDTH-1];
                w_res       = shift_en_q ? w_shift_val : a_q;
                w_carry     = shift_en_q & w_shift_out;
            end
            c_OP_SRL: begin
                w_shift_val = {1'b0, a_q[WIDTH-1:1]};
                w_shift_out = a_q[0];
                w_res       = shift_en_q ? w_shift_val : a_q;
                w_carry     = shift_en_q & w_shift_out;
            end
            default: w_res = '0;
        endcase
    end

    // Next-state and output-register update for the controller
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        shift_en_d  = shift_en_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        w_mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d = SELECT;
                    a_d  = DATA1;
                    b_d  = DATA2;
                    if (SELECT == c_OP_MUL) begin
                        w_mul_start = 1'b1;
                        state_d     = ST_MUL;
                    end else begin
                        state_d = ST_EXEC;
                        if (is_shift(SELECT)) begin
                            // A zero shift amount still takes one cycle
                            shift_en_d = (w_shamt != '0);
                            cnt_d      = (w_shamt == '0) ? SHW'(1) : w_shamt;
                        end else begin
                            shift_en_d = 1'b0;
                            cnt_d      = SHW'(1);
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (shift_en_q) begin
                    a_d = w_shift_val;
                end
                if (cnt_q == SHW'(1)) begin
                    result_d    = w_res;
                    result_hi_d = '0;
                    carry_d     = w_carry;
                    ovf_d       = w_ovf;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - SHW'(1);
                end
            end
            ST_MUL: begin
                if (w_mul_last) begin
                    result_d    = w_mul_product[WIDTH-1:0];
                    result_hi_d = w_mul_product[2*WIDTH-1:WIDTH];
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller and output registers; reset aborts any operation in flight
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            op_q        <= c_OP_FWD;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            shift_en_q  <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            shift_en_q  <= shift_en_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign RESULT    = result_q;
    assign RESULT_HI = result_hi_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DONE      = done_q;
    assign ZERO      = ~|{result_hi_q, result_q};
    assign CARRY     = carry_q;
    assign OVERFLOW  = ovf_q;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Scoreboard bench for alu_seq. The driver pushes expected
//                responses from an arithmetic reference model; a monitor pops
//                and compares on every DONE, including latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         START = 1'b0;
    logic [2:0]   SELECT = 3'd0;
    logic [W-1:0] DATA1 = '0;
    logic [W-1:0] DATA2 = '0;
    logic [W-1:0] RESULT;
    logic [W-1:0] RESULT_HI;
    logic         BUSY;
    logic         DONE;
    logic         ZERO;
    logic         CARRY;
    logic         OVERFLOW;

    alu_seq #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .SELECT    (SELECT),
        .DATA1     (DATA1),
        .DATA2     (DATA2),
        .RESULT    (RESULT),
        .RESULT_HI (RESULT_HI),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ZERO      (ZERO),
        .CARRY     (CARRY),
        .OVERFLOW  (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // Rising-edge counter used to measure latency
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         carry;
        logic         ovf;
        int           lat;
        int           acc;   // edge number at which START is accepted
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: plain integer arithmetic on unsigned/signed values
    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   sh;
        int   r;
        int   p;
        int   sa;
        int   sb;
        int   ss;
        sh      = b % W;
        sa      = (a >= 2**(W-1)) ? a - 2**W : a;
        sb      = (b >= 2**(W-1)) ? b - 2**W : b;
        r       = 0;
        e.hi    = '0;
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        e.lat   = 1;
        e.acc   = 0;
        case (op)
            0: r = b;
            1: begin
                r       = a + b;
                e.carry = (r >= 2**W);
                ss      = sa + sb;
                e.ovf   = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
            end
            2: r = a & b;
            3: r = a | b;
            4: begin
                r       = a - b;
                e.carry = (a < b);
                ss      = sa - sb;
                e.ovf   = (ss > 2**(W-1) - 1) || (ss < -(2**(W-1)));
            end
            5: begin
                r       = a << sh;
                e.carry = (sh != 0) && (((a >> (W - sh)) & 1) != 0);
                e.lat   = (sh == 0) ? 1 : sh;
            end
            6: begin
                r       = a >> sh;
                e.carry = (sh != 0) && (((a >> (sh - 1)) & 1) != 0);
                e.lat   = (sh == 0) ? 1 : sh;
            end
            default: begin
                p     = a * b;
                r     = p % (2**W);
                e.hi  = W'(p / (2**W));
                e.lat = W;
            end
        endcase
        e.res  = r[W-1:0];
        e.zero = (e.res == '0) && (e.hi == '0);
        return e;
    endfunction

    // Issue one operation; called at a falling edge. Optionally keeps START
    // asserted with junk operands while the DUT is busy.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit noisy);
        exp_t e;
        int   guard;
        guard = 0;
        START = 1'b0;
        while (BUSY !== 1'b0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 100) begin
            errors++;
            checks++;
            $display("FAIL idle_wait: BUSY still %b after %0d cycles, required 0", BUSY, guard);
        end
        e     = model(int'(op), int'(a), int'(b));
        e.acc = cyc + 1;
        exp_q.push_back(e);
        START  = 1'b1;
        SELECT = op;
        DATA1  = a;
        DATA2  = b;
        @(negedge CLK);
        if (noisy) begin
            for (int k = 1; k < e.lat; k++) begin
                START  = 1'b1;
                SELECT = 3'($urandom);
                DATA1  = W'($urandom);
                DATA2  = W'($urandom);
                @(negedge CLK);
            end
        end
        START = 1'b0;
        DATA1 = W'($urandom);
        DATA2 = W'($urandom);
    endtask

    // Monitor: compare every completed operation against the scoreboard
    always @(negedge CLK) begin
        if (RESET === 1'b0 && DONE === 1'b1) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_done: got DONE=1 with no pending op, required DONE=0");
            end else begin
                mon_e = exp_q.pop_front();
                check("result",    32'(RESULT),    32'(mon_e.res));
                check("result_hi", 32'(RESULT_HI), 32'(mon_e.hi));
                check("zero",      32'(ZERO),      32'(mon_e.zero));
                check("carry",     32'(CARRY),     32'(mon_e.carry));
                check("overflow",  32'(OVERFLOW),  32'(mon_e.ovf));
                check("busy_at_done", 32'(BUSY),   32'd0);
                check("latency",   32'(cyc - mon_e.acc), 32'(mon_e.lat));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_result"},    32'(RESULT),    32'd0);
        check({tag, "_result_hi"}, 32'(RESULT_HI), 32'd0);
        check({tag, "_busy"},      32'(BUSY),      32'd0);
        check({tag, "_done"},      32'(DONE),      32'd0);
        check({tag, "_zero"},      32'(ZERO),      32'd1);
        check({tag, "_carry"},     32'(CARRY),     32'd0);
        check({tag, "_overflow"},  32'(OVERFLOW),  32'd0);
    endtask

    // Main stimulus sequence
    initial begin
        int guard;
        repeat (2) @(negedge CLK);
        check_reset_values("por");
        RESET = 1'b0;
        @(negedge CLK);

        // Directed corner cases
        issue(3'b001, 8'h7F, 8'h01, 1'b0);   // ADD overflow
        issue(3'b100, 8'h05, 8'h07, 1'b0);   // SUB borrow
        issue(3'b101, 8'h81, 8'h03, 1'b0);   // SLL by 3
        issue(3'b110, 8'h81, 8'h00, 1'b0);   // SRL by 0
        issue(3'b111, 8'hFF, 8'hFF, 1'b0);   // MUL max
        issue(3'b111, 8'h10, 8'h00, 1'b0);   // MUL by zero
        issue(3'b000, 8'h12, 8'h00, 1'b0);   // FORWARD zero
        issue(3'b101, 8'h81, 8'h0B, 1'b1);   // shamt masked to 3, START while busy
        issue(3'b111, 8'h3C, 8'h5A, 1'b1);   // MUL with START while busy
        issue(3'b110, 8'hF0, 8'h07, 1'b1);   // SRL by 7

        // Randomized traffic, back-to-back where the driver allows it
        for (int i = 0; i < 150; i++) begin
            issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom),
                  1'($urandom_range(0, 1)));
        end

        // Abort a multiply in its 4th cycle
        issue(3'b111, 8'hAB, 8'hCD, 1'b0);
        check("mul_busy", 32'(BUSY), 32'd1);
        repeat (2) @(negedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        check_reset_values("abort");
        exp_q.delete();
        @(negedge CLK);
        RESET = 1'b0;
        repeat (12) @(negedge CLK);

        issue(3'b001, 8'h02, 8'h03, 1'b0);

        // Drain outstanding responses
        guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: %0d ops still pending, required 0", exp_q.size());
        end
        @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the team's combinational 8-bit ALU. Adds subtract, barrel-free shifts and an iterative multiplier behind a start/busy/done handshake, with registered result and status flags. Sits between the register file read ports and the write-back mux of the CPU datapath; the control unit stalls the PC while `BUSY` is high.

## Interface
- `WIDTH`, 8: operand/result width in bits, ≥4, power of two.
- `SHW`, log2(WIDTH): shift-amount width (derived, not overridden).
- `CLK` in 1: rising-edge clock.
- `RESET` in 1: asynchronous, active-high; clears all state and outputs.
- `START` in 1: request; sampled only in IDLE.
- `SELECT` in 3: opcode, sampled with `START`.
- `DATA1` in WIDTH: operand A, sampled with `START`.
- `DATA2` in WIDTH: operand B, sampled with `START`.
- `RESULT` out WIDTH: registered result (low half for MUL).
- `RESULT_HI` out WIDTH: upper half of MUL product; 0 for all other ops.
- `BUSY` out 1: high from the edge accepting `START` until the edge completing the op.
- `DONE` out 1: one-cycle pulse, results/flags valid.
- `ZERO` out 1: `RESULT`==0 (and `RESULT_HI`==0 for MUL).
- `CARRY` out 1: carry-out for ADD, borrow (A<B unsigned) for SUB, last bit shifted out for shifts; else 0.
- `OVERFLOW` out 1: two's-complement overflow for ADD/SUB; else 0.

## Operation
- Opcodes: 000 FORWARD (B), 001 ADD, 010 AND, 011 OR, 100 SUB (A−B), 101 SLL (A << B[SHW-1:0]), 110 SRL logical, 111 MUL unsigned (A×B, 2·WIDTH product).
- FSM: IDLE, EXEC, MUL.
  - IDLE: `START`=1 → latch `SELECT`, operands; opcodes 000–100 → EXEC with 1-cycle count; 101/110 → EXEC with count = max(1, shamt); 111 → MUL with count = WIDTH.
  - EXEC: shifts move one bit per cycle; count reaches 0 → write outputs, pulse `DONE`, → IDLE.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, LSB first; after WIDTH iterations → write outputs, pulse `DONE`, → IDLE.
- `START` while `BUSY` is ignored; operand changes during an op have no effect.
- All arithmetic modulo 2^WIDTH except MUL (full 2·WIDTH).
- `RESULT`, `RESULT_HI` and flags hold their last values until the next `DONE`.
- Back-to-back: `START` may be asserted in the same cycle `DONE` is high (FSM is in IDLE then); it is accepted.

## Timing
- Reset values: `RESULT`=0, `RESULT_HI`=0, `BUSY`=0, `DONE`=0, `ZERO`=1, `CARRY`=0, `OVERFLOW`=0, FSM=IDLE.
- `START` accepted at edge N → `BUSY`=1 after N.
- Latency (edge N to edge where `DONE` rises): 1 for 000–100; max(1, shamt) for shifts; WIDTH for MUL. `BUSY` falls on the same edge that `DONE` rises.
- `RESET` asserted mid-operation: immediate abort, all outputs to reset values, no `DONE`.
- Shamt ≥ WIDTH impossible (masked to SHW bits); shamt 0 → result = A, `CARRY`=0, latency 1.

## Structure
- Shared package/header `alu_defs.vh`: opcode `define`s (`ALU_FWD`…`ALU_MUL`), FSM state encodings.
- One sub-module: `alu_mul_iter` (shift-add datapath: accumulator, multiplier shift register, counter; `start`/`done` interface). Flags and single-cycle ops stay in the top.
- `ZERO` computed as reduction-NOR over the registered result, generalising the existing 8-input NOR.

## Test plan (WIDTH=8)
- Reset: assert `RESET` async mid-cycle → all outputs at reset values immediately; `ZERO`=1.
- ADD 0x7F+0x01 → `RESULT`=0x80, `OVERFLOW`=1, `CARRY`=0, `DONE` 1 cycle after accept; SUB 0x05−0x07 → 0xFE, `CARRY`=1.
- SLL 0x81 by 3 → `RESULT`=0x08, `CARRY`=0 (last out bit), latency 3; SRL 0x81 by 0 → 0x81, latency 1.
- MUL 0xFF×0xFF → `RESULT_HI`=0xFE, `RESULT`=0x01, `ZERO`=0, latency 8; MUL 0x10×0x00 → 0, `ZERO`=1.
- `START` with new operands while `BUSY` → ignored, original result produced; `START` in `DONE` cycle → accepted.
- `RESET` in 4th cycle of MUL → no `DONE`, outputs reset; next ADD 2+3 → 5 normally.
